// File: rtl/aes_dec_arbiter_pkg.sv
// rtl/aes_dec_arbiter_pkg.sv - shared FSM encodings and width defaults for aes_dec_arbiter
package aes_dec_arbiter_pkg;

    localparam int DATA_W_DEF = 128;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

endpackage

// File: rtl/aes_dec_arbiter_rr_arb2.sv
// rtl/aes_dec_arbiter_rr_arb2.sv - combinational 2-way round-robin pick
module aes_dec_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b10) begin
            grant = 1'b1;
        end else if (req == 2'b11) begin
            grant = ~last;
        end
    end

endmodule

// File: rtl/aes_dec_arbiter.sv
// rtl/aes_dec_arbiter.sv - shares one inv_aes core between two requesters
module aes_dec_arbiter
    import aes_dec_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 10
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] text0,
    input  logic [DATA_W-1:0] text1,
    input  logic [DATA_W-1:0] key0,
    input  logic [DATA_W-1:0] key1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic              grant_id,
    output logic              ctrl_busy,
    output logic              core_start,
    output logic [DATA_W-1:0] core_text,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_busy,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result
);

    logic [2:0]        state_q, state_d;
    logic              grant_id_q, grant_id_d;
    logic              rr_q, rr_d;
    logic [TO_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0] text_q, text_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              arb_grant, arb_valid;
    logic              timeout_hit;
    logic              ack;

    aes_dec_arbiter_rr_arb2 u_arb (
        .req   ({req1, req0}),
        .last  (rr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign timeout_hit = (count_q == TO_W'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_d       = rr_q;
        count_d    = count_q;
        text_d     = text_q;
        key_d      = key_q;
        result_d   = result_q;
        ack        = 1'b0;
        err        = 1'b0;
        result     = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_id_d = arb_grant;
                    text_d     = arb_grant ? text1 : text0;
                    key_d      = arb_grant ? key1 : key0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                count_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                count_d = count_q + 1'b1;
                // A completion seen in the timeout cycle still counts as success.
                if (state_q == ST_WAIT_DONE && core_done && !core_busy) begin
                    result_d = core_result;
                    state_d  = ST_RESP;
                end else if (timeout_hit) begin
                    ack     = 1'b1;
                    err     = 1'b1;
                    rr_d    = grant_id_q;
                    state_d = ST_IDLE;
                end else if (state_q == ST_WAIT_BUSY && core_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                ack     = 1'b1;
                result  = result_q;
                rr_d    = grant_id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q    <= ST_IDLE;
            grant_id_q <= 1'b0;
            rr_q       <= 1'b1;
            count_q    <= '0;
            text_q     <= '0;
            key_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            text_q     <= text_d;
            key_q      <= key_d;
            result_q   <= result_d;
        end
    end

    assign ack0       = ack & ~grant_id_q;
    assign ack1       = ack & grant_id_q;
    assign grant_id   = grant_id_q;
    assign ctrl_busy  = (state_q != ST_IDLE);
    assign core_start = (state_q == ST_ISSUE);
    assign core_text  = text_q;
    assign core_key   = key_q;

endmodule
